// File: rtl/gshare_predictor_pkg.sv
// Shared gshare helpers: state encoding, counter init/step and the PC/history hash.
package gshare_predictor_pkg;

  typedef logic stateT;
  localparam stateT STATE_INIT = 1'b0;
  localparam stateT STATE_RUN  = 1'b1;

  // Weakly-not-taken: one below the taken threshold, or 0 for 1-bit counters.
  function automatic logic [3:0] counterInit(input int width);
    return (width <= 1) ? 4'd0 : 4'((1 << (width - 1)) - 1);
  endfunction

  function automatic logic [3:0] satStep(input logic [3:0] cnt, input logic taken,
                                         input int width);
    logic [3:0] maxVal;
    maxVal = 4'((1 << width) - 1);
    if (taken) return (cnt == maxVal) ? cnt : cnt + 4'd1;
    return (cnt == 4'd0) ? cnt : cnt - 4'd1;
  endfunction

  function automatic logic [31:0] hashIndex(input logic [31:0] pc, input logic [31:0] hist,
                                            input int indexWidth);
    logic [31:0] mask;
    mask = 32'((64'd1 << indexWidth) - 64'd1);
    return ((pc >> 2) ^ hist) & mask;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch/ROB-facing bus of the gshare predictor; slave is the predictor side.
interface gshare_predictor_if #(parameter int INDEX_WIDTH = 10);
  logic                   ready;
  logic                   lookupValid;
  logic [31:0]            lookupAddr;
  logic                   jumpValid;
  logic                   jump;
  logic [INDEX_WIDTH-1:0] lookupIndex;
  logic                   updateValid;
  logic [INDEX_WIDTH-1:0] updateIndex;
  logic                   updateTaken;
  logic                   flushIn;

  modport master (
    input  ready, jumpValid, jump, lookupIndex,
    output lookupValid, lookupAddr, updateValid, updateIndex, updateTaken, flushIn
  );

  modport slave (
    output ready, jumpValid, jump, lookupIndex,
    input  lookupValid, lookupAddr, updateValid, updateIndex, updateTaken, flushIn
  );
endinterface

// File: rtl/gshare_counter_table.sv
// Saturating-counter storage: combinational read, synchronous write, init sweep port.
module gshare_counter_table
  import gshare_predictor_pkg::*;
#(
  parameter int INDEX_WIDTH   = 10,
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                   clockIn,
  input  logic                   initEn,
  input  logic [INDEX_WIDTH-1:0] initPtr,
  input  logic                   updEn,
  input  logic [INDEX_WIDTH-1:0] updIndex,
  input  logic                   updTaken,
  input  logic [INDEX_WIDTH-1:0] rdIndex,
  output logic                   rdTaken
);
  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [COUNTER_WIDTH-1:0] mem [DEPTH];
  logic [3:0]               updCur;

  assign updCur  = 4'(mem[updIndex]);
  assign rdTaken = mem[rdIndex][COUNTER_WIDTH-1];

  // No reset: the init sweep is what gives every entry a defined value.
  always_ff @(posedge clockIn) begin
    if (initEn)
      mem[initPtr] <= COUNTER_WIDTH'(counterInit(COUNTER_WIDTH));
    else if (updEn)
      mem[updIndex] <= COUNTER_WIDTH'(satStep(updCur, updTaken, COUNTER_WIDTH));
  end
endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor top: init FSM, history registers, registered prediction.
// Optional speculative history is enabled by defining GSHARE_SPEC_HISTORY_EN.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int INDEX_WIDTH   = 10,
  parameter int HISTORY_WIDTH = 8,
  parameter int COUNTER_WIDTH = 2
) (
  input logic               clockIn,
  input logic               resetIn,
  gshare_predictor_if.slave bus
);
  localparam int H = HISTORY_WIDTH;

  stateT                  state, stateNext;
  logic [INDEX_WIDTH-1:0] initPtr;
  logic                   initEn, ready;
  logic                   accept, updEn, pred;
  logic [INDEX_WIDTH-1:0] idx;
  logic [H-1:0]           commitHistory, commitNext, lookupHistory;
  logic [H:0]             commitShift;
  logic                   jumpValidQ, jumpQ;
  logic [INDEX_WIDTH-1:0] indexQ;

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) state <= STATE_INIT;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == STATE_INIT && initPtr == {INDEX_WIDTH{1'b1}}) stateNext = STATE_RUN;
  end

  always_comb begin
    initEn = (state == STATE_INIT);
    ready  = (state == STATE_RUN);
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn)    initPtr <= '0;
    else if (initEn) initPtr <= initPtr + INDEX_WIDTH'(1);
  end

  assign updEn       = bus.updateValid & ready;
  assign accept      = bus.lookupValid & ready & ~bus.flushIn;
  assign commitShift = {commitHistory, bus.updateTaken};
  assign commitNext  = updEn ? commitShift[H-1:0] : commitHistory;

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) commitHistory <= '0;
    else          commitHistory <= commitNext;
  end

`ifdef GSHARE_SPEC_HISTORY_EN
  logic [H-1:0] specHistory;
  logic [H:0]   specShift;

  assign specShift = {specHistory, pred};

  // Flush repairs from the committed history including this cycle's commit.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn)                 specHistory <= '0;
    else if (ready & bus.flushIn) specHistory <= commitNext;
    else if (accept)              specHistory <= specShift[H-1:0];
  end

  assign lookupHistory = specHistory;
`else
  assign lookupHistory = commitHistory;
`endif

  assign idx = INDEX_WIDTH'(hashIndex(bus.lookupAddr, 32'(lookupHistory), INDEX_WIDTH));

  gshare_counter_table #(
    .INDEX_WIDTH  (INDEX_WIDTH),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) uTable (
    .clockIn (clockIn),
    .initEn  (initEn),
    .initPtr (initPtr),
    .updEn   (updEn),
    .updIndex(bus.updateIndex),
    .updTaken(bus.updateTaken),
    .rdIndex (idx),
    .rdTaken (pred)
  );

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      jumpValidQ <= 1'b0;
      jumpQ      <= 1'b0;
      indexQ     <= '0;
    end else begin
      jumpValidQ <= accept;
      if (accept) begin
        jumpQ  <= pred;
        indexQ <= idx;
      end
    end
  end

  assign bus.ready       = ready;
  assign bus.jumpValid   = jumpValidQ;
  assign bus.jump        = jumpQ;
  assign bus.lookupIndex = indexQ;
endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector table plus randomized traffic
// against an arithmetic reference model (index 4 bits, history 4 bits, 2-bit counters).
module tb_gshare_predictor;
  localparam int IW     = 4;
  localparam int HW     = 4;
  localparam int CW     = 2;
  localparam int DEPTH  = 1 << IW;
  localparam int HDEPTH = 1 << HW;
  localparam int MAXC   = (1 << CW) - 1;
  localparam int HALF   = 1 << (CW - 1);
  localparam int INITV  = HALF - 1;
`ifdef GSHARE_SPEC_HISTORY_EN
  localparam bit SPEC = 1'b1;
`else
  localparam bit SPEC = 1'b0;
`endif

  logic clk, rstN;
  gshare_predictor_if #(.INDEX_WIDTH(IW)) bus();

  gshare_predictor #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW), .COUNTER_WIDTH(CW)) dut (
    .clockIn(clk),
    .resetIn(rstN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int cnt [DEPTH];
  int cH, sH, initCnt;
  bit mReady, expJv, expJump;
  int expIdx;

  typedef struct {
    bit          lv;
    logic [31:0] addr;
    bit          uv;
    int          ui;
    bit          ut;
    bit          fl;
    bit          ejv;
    bit          ej;
    int          eidx;
  } vecT;
  vecT vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mReady = 0; initCnt = 0; cH = 0; sH = 0;
    expJv = 0; expJump = 0; expIdx = 0;
    for (int i = 0; i < DEPTH; i++) cnt[i] = INITV;
  endtask

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic modelEdge();
    int  hist, idx;
    bit  acc, pred;
    if (!mReady) begin
      expJv = 0;
      initCnt++;
      if (initCnt == DEPTH) mReady = 1;
      return;
    end
    acc  = bus.lookupValid && !bus.flushIn;
    hist = SPEC ? sH : cH;
    idx  = (int'(bus.lookupAddr[31:2]) ^ hist) & (DEPTH - 1);
    pred = cnt[idx] >= HALF;
    expJv = acc;
    if (acc) begin expJump = pred; expIdx = idx; end
    if (bus.updateValid) begin
      if (bus.updateTaken) cnt[bus.updateIndex] = (cnt[bus.updateIndex] == MAXC) ? MAXC : cnt[bus.updateIndex] + 1;
      else                 cnt[bus.updateIndex] = (cnt[bus.updateIndex] == 0) ? 0 : cnt[bus.updateIndex] - 1;
      cH = (cH * 2 + int'(bus.updateTaken)) % HDEPTH;
    end
    if (SPEC) begin
      if (bus.flushIn) sH = cH;
      else if (acc)    sH = (sH * 2 + int'(pred)) % HDEPTH;
    end
  endtask

  task automatic drive(input bit lv, input logic [31:0] addr, input bit uv, input int ui,
                       input bit ut, input bit fl);
    bus.lookupValid = lv;
    bus.lookupAddr  = addr;
    bus.updateValid = uv;
    bus.updateIndex = IW'(ui);
    bus.updateTaken = ut;
    bus.flushIn     = fl;
  endtask

  task automatic checkModel();
    check("ready", 32'(bus.ready), 32'(mReady));
    check("jumpValid", 32'(bus.jumpValid), 32'(expJv));
    if (expJv) begin
      check("jump", 32'(bus.jump), 32'(expJump));
      check("lookupIndex", 32'(bus.lookupIndex), 32'(expIdx));
    end
  endtask

  // Called at posedge+1; leaves the time at the next posedge+1.
  task automatic cycle();
    modelEdge();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic randDrive();
    drive($urandom_range(3) != 0, $urandom, $urandom_range(1) == 1, int'($urandom_range(DEPTH - 1)),
          $urandom_range(1) == 1, $urandom_range(7) == 0);
  endtask

  function automatic vecT mk(bit lv, logic [31:0] addr, bit uv, int ui, bit ut, bit fl,
                             bit ejv, bit ej, int eidx);
    vecT v;
    v.lv = lv; v.addr = addr; v.uv = uv; v.ui = ui; v.ut = ut; v.fl = fl;
    v.ejv = ejv; v.ej = ej; v.eidx = eidx;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Directed sequence; every history-diverging step is followed by a flush so the
    // expected values hold with and without speculative history.
    vecs.push_back(mk(1, 32'h00, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h04, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 32'h08, 0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 32'h14, 0, 0, 0, 0, 1, 0, 5));
    vecs.push_back(mk(0, 32'h00, 1, 5, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00, 1, 5, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h18, 0, 0, 0, 0, 1, 1, 5));
    vecs.push_back(mk(0, 32'h00, 1, 5, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00, 1, 5, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h2C, 0, 0, 0, 0, 1, 1, 5));
    vecs.push_back(mk(0, 32'h00, 1, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00, 1, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00, 1, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00, 1, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h08, 0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 32'h08, 1, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0C, 0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0C, 1, 2, 1, 0, 1, 0, 2));
    vecs.push_back(mk(0, 32'h00, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 1, 1, 2));

    rstN = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(bus.ready), 32'd0);
    check("reset jumpValid", 32'(bus.jumpValid), 32'd0);
    check("reset jump", 32'(bus.jump), 32'd0);
    check("reset lookupIndex", 32'(bus.lookupIndex), 32'd0);
    rstN = 1'b1;

    // Init sweep with live-looking traffic that must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      randDrive();
      cycle();
    end

    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].addr, vecs[i].uv, vecs[i].ui, vecs[i].ut, vecs[i].fl);
      cycle();
      check($sformatf("vec%0d jumpValid", i), 32'(bus.jumpValid), 32'(vecs[i].ejv));
      if (vecs[i].ejv) begin
        check($sformatf("vec%0d jump", i), 32'(bus.jump), 32'(vecs[i].ej));
        check($sformatf("vec%0d lookupIndex", i), 32'(bus.lookupIndex), 32'(vecs[i].eidx));
      end
    end

    for (int n = 0; n < 300; n++) begin
      randDrive();
      cycle();
      if (n == 150) begin
        // Force an accepted lookup, then pull reset mid-cycle.
        drive(1, $urandom, 0, 0, 0, 0);
        cycle();
        #1;
        rstN = 1'b0;
        #1;
        check("async reset ready", 32'(bus.ready), 32'd0);
        check("async reset jumpValid", 32'(bus.jumpValid), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised global-history branch direction predictor for the instruction fetch path. It is the next generation of the single-table local predictor. Each lookup hashes the fetch PC with a global history register into a table of saturating counters, and returns a registered prediction plus the table index used. The reorder buffer carries that index back with the branch for training, and uses it to repair speculative history on a flush.

## Interface
- INDEX_WIDTH, 10: log2 of the counter table depth.
- HISTORY_WIDTH, 8: global history length; legal range 1..INDEX_WIDTH.
- COUNTER_WIDTH, 2: saturating counter width; legal range 1..4.
- clockIn  input  1  sole clock, rising edge.
- resetIn  input  1  asynchronous, active-low reset.
- ready  output  1  high once table initialisation is complete.
- lookupValid  input  1  fetch lookup request (icache).
- lookupAddr  input  32  fetch PC.
- jumpValid  output  1  prediction valid, one cycle after an accepted lookup.
- jump  output  1  predicted taken.
- lookupIndex  output  INDEX_WIDTH  table index used, returned alongside jump.
- updateValid  input  1  branch commit (reorder buffer).
- updateIndex  input  INDEX_WIDTH  index captured at lookup.
- updateTaken  input  1  resolved direction.
- flushIn  input  1  pipeline flush or mispredict recovery (reorder buffer).

## Operation
- FSM states: INIT and RUN.
- Asynchronous reset forces:
  - state = INIT, init pointer = 0, ready = 0;
  - jumpValid = 0, jump = 0, lookupIndex = 0;
  - specHistory = 0, commitHistory = 0.
- The table itself has no reset.
- INIT: writes weakly-not-taken, 2^(COUNTER_WIDTH-1)-1, to entry[ptr] and increments ptr once per cycle.
  - After the write to entry 2^INDEX_WIDTH-1, the FSM moves to RUN and ready rises the next cycle.
  - For COUNTER_WIDTH=1 the init value is 0.
  - Lookups, updates and flushes are ignored during INIT.
- Index: lookupAddr[INDEX_WIDTH+1:2] XOR {zero-extend(specHistory)}; history occupies the low bits.
- Prediction: jump = MSB of the counter.
- Update: on updateValid, entry[updateIndex] is incremented if updateTaken and decremented otherwise.
  - Counters saturate at 0 and at 2^COUNTER_WIDTH-1; they never wrap.
- commitHistory <= {commitHistory[H-2:0], updateTaken} on updateValid.
- Accepted lookup (lookupValid & ready & !flushIn): specHistory shifts in the predicted bit.
- Flush: specHistory <= commitHistory value after this cycle's update is applied. That is the shifted value if updateValid is high in the same cycle.
- Flush with lookupValid in the same cycle: the lookup is dropped, jumpValid = 0 next cycle, and the flush wins.
- Lookup and update to the same index in the same cycle: the lookup reads the pre-update counter. There is no bypass.

## Timing
- Lookup accepted at edge t produces jump, jumpValid and lookupIndex valid after edge t. They are registered and stay valid for one cycle only.
- Throughput: one lookup per cycle, with no stall while ready=1.
- A counter update is visible to lookups issued in the cycle after updateValid.
- A flush takes effect at the same edge; a lookup in the next cycle uses the repaired history.
- Initialisation takes 2^INDEX_WIDTH cycles from reset deassertion to the RUN transition.
- Reset asserted mid-operation: all outputs drop immediately and the sweep restarts from 0.

## Configuration
- GSHARE_SPEC_HISTORY_EN defined:
  - specHistory is maintained as above;
  - flushIn restores it from commitHistory.
- Undefined:
  - there is no specHistory register;
  - the index uses commitHistory;
  - flushIn only drops a same-cycle lookup;
  - predictions never alter history.

## Structure
- Shared predictor package holds:
  - the counter init function, returning a weakly-not-taken value for a given width;
  - the saturating increment/decrement function;
  - the index hash function;
  - localparams for the INIT/RUN state encoding.
- One sub-module: gshare_counter_table. It holds the synchronous-write, combinational-read storage plus the init sweep write port.
- Top level keeps the history registers and the output pipeline.

## Test plan
- Reset low then high, INDEX_WIDTH=4 → ready=0 for 16 cycles, then 1. The first lookup of any address returns jump=0, jumpValid=1.
- Two commits taken=1 to index 5, then a lookup hitting index 5 → jump=1. A third taken commit leaves the counter at 3; one not-taken commit then still gives jump=1.
- Four not-taken commits to index 2 from the init value → counter stays at 0, with no wrap to 3.
- Spec on: lookups at PCs 0x0, 0x4, 0x8 with committed history 0 → lookupIndex values are 0, 1^h1, 2^h2. Then flushIn → specHistory equals commitHistory, and the next lookup index is pc[5:2]^commitHistory.
- flushIn, updateValid(taken=1) and lookupValid all in one cycle → jumpValid=0 next cycle and specHistory=commitHistory=...0001.
- Reset pulsed low during RUN → jumpValid and ready drop asynchronously and a full 2^INDEX_WIDTH-cycle re-init follows.
